rto_core_param: RTL and testbench
=================================

// Module: rto_core_param
// PURPOSE
//  Parametrised real-time-output core. Buffers timestamped words {timestamp, data} in an internal FWFT FIFO.
//  Releases the head word to rto_out when the global counter equals its timestamp.
//  Over the fixed-width core it adds: configurable widths/depth, a late-event policy, sticky error flags
//  with clear, and a fill-level output. Sits between the AXI/DMA write path and per-channel output drivers.
// PARAMETERS
//  TS_W        64    timestamp/counter width, unsigned
//  DATA_W      64    payload width; entry ENTRY_W = TS_W+DATA_W, timestamp in MSBs
//  DEPTH       8192  FIFO entries, power of two, >=4
//  FULL_THRESH 8100  full asserts when level >= FULL_THRESH (<= DEPTH)
//  LATE_POLICY 0     0: drop late word; 1: emit late word on rto_out as well as flag it
//  CNT_W       16    error counter width (RTO_ERR_COUNT_EN only)
// PORTS
//  clk                   in   1          core clock
//  reset_n               in   1          asynchronous, active-low reset
//  auto_start            in   1          enables head compare/pop
//  flush                 in   1          synchronous clear of FIFO, outputs and error state
//  err_clear             in   1          clears sticky flags (and counters)
//  write                 in   1          push fifo_din
//  fifo_din              in   ENTRY_W    {timestamp, data}
//  counter               in   TS_W       global time
//  counter_matched       out  1          1-cycle pulse: rto_out updated
//  rto_out               out  ENTRY_W    last released entry
//  timestamp_error       out  1          1-cycle pulse: late head popped
//  timestamp_error_data  out  ENTRY_W    last late entry
//  overflow_error        out  1          1-cycle pulse: write rejected
//  overflow_error_data   out  ENTRY_W    last rejected fifo_din
//  ts_err_sticky         out  1          set by timestamp_error, held until err_clear/flush
//  ovf_err_sticky        out  1          set by overflow_error, held until err_clear/flush
//  full / empty          out  1          level>=FULL_THRESH / level==0
//  level                 out  $clog2(DEPTH+1)  entries stored
// BEHAVIOUR
//  Reset (reset_n=0, async) and flush (sync, priority over everything else): FIFO emptied.
//    All outputs 0, except empty=1. Writes and pops in a flush cycle are discarded.
//  Push: write && !full -> stored at clk edge; word visible at head for compare next cycle.
//    full is from the registered level, so a pop in the same cycle does not admit a write at the threshold.
//  Overflow: write && full -> word dropped, overflow_error=1 next cycle, overflow_error_data<=fifo_din.
//  Compare, combinational on head when !empty && auto_start (unsigned):
//    head_ts==counter -> match: pop; next cycle rto_out<=head, counter_matched=1.
//    head_ts< counter -> late: pop; next cycle timestamp_error=1, timestamp_error_data<=head;
//      if LATE_POLICY=1 also rto_out<=head, counter_matched=1.
//    head_ts> counter -> hold.
//  At most one pop per cycle. A back-to-back equal timestamp releases on the next cycle only if still ==counter; otherwise it is late.
//  Simultaneous push+pop: both occur, level unchanged. Push into empty: no pop that cycle (head not yet valid).
//  auto_start=0: no pops, no timestamp errors; writes and overflow still active.
//  Sticky: set has priority over err_clear in the same cycle.
//  No counter wrap handling: counter is monotonic for TS_W=64.
//  Pulses not asserted -> 0; data/rto_out registers hold their last value.
// CONFIGURATION
//  `RTO_ERR_COUNT_EN defined: adds outputs ts_err_count, ovf_err_count [CNT_W].
//    Each increments on its error pulse, saturates at all-ones, and is cleared by err_clear/flush/reset.
//  Undefined: ports and logic absent; all other behaviour identical.
// STRUCTURE
//  rto_pkg: ENTRY_W function, rto_entry_t struct {ts, data}, LATE_DROP/LATE_EMIT localparams.
//  Sub-module rto_sync_fifo: inferred-BRAM FWFT FIFO with level, sync clear, async reset.
//  rto_core_param holds compare, pop, error and output logic.
// TESTING
//  1 Push ts=100,d=0xA; counter 95..105, auto_start=1 -> counter_matched at cycle after counter==100, rto_out={100,0xA}.
//  2 Push ts=50, counter=60 -> timestamp_error pulse, data={50,..}, sticky=1.
//    Run with LATE_POLICY=0: rto_out unchanged. Run with LATE_POLICY=1: rto_out={50,..}, counter_matched=1.
//  3 DEPTH=16,FULL_THRESH=14: 15 writes -> 14 stored, full=1, 15th gives overflow_error, overflow_error_data=15th word, level=14.
//  4 Fill 4 words, assert flush mid-release -> level=0, empty=1, all outputs 0 next cycle. Repeat with reset_n pulse asynchronously.
//  5 Continuous push+pop at level 5 -> level stays 5. err_clear same cycle as new error -> sticky remains 1.
//  6 `RTO_ERR_COUNT_EN, CNT_W=2: 5 overflows -> ovf_err_count=3. err_clear -> 0.

Source files
------------

// File: rtl/rto_pkg.sv
// Shared types and helpers for the real-time-output core.
package rto_pkg;

    localparam int LATE_DROP  = 0;
    localparam int LATE_EMIT  = 1;
    localparam int DEF_TS_W   = 64;
    localparam int DEF_DATA_W = 64;

    // Reference layout of a stored word: timestamp occupies the MSBs.
    typedef struct packed {
        logic [DEF_TS_W-1:0]   ts;
        logic [DEF_DATA_W-1:0] data;
    } rto_entry_t;

    function automatic int entry_w(input int ts_w, input int data_w);
        return ts_w + data_w;
    endfunction

endpackage

// File: rtl/rto_if.sv
// Write-side bus of the real-time-output core: push strobe, word and fill status.
interface rto_if #(
    parameter int TS_W   = 64,
    parameter int DATA_W = 64,
    parameter int DEPTH  = 8192
);
    import rto_pkg::*;

    localparam int ENTRY_W = entry_w(TS_W, DATA_W);
    localparam int LW      = $clog2(DEPTH + 1);

    // write is a single-cycle push strobe with no ready: full is advisory back-pressure
    // taken from the registered level, and a write presented while full is dropped and reported.
    logic               write;
    logic [ENTRY_W-1:0] fifo_din;
    logic               full;
    logic               empty;
    logic [LW-1:0]      level;

    modport master (output write, output fifo_din, input full, input empty, input level);
    modport slave  (input write, input fifo_din, output full, output empty, output level);

endinterface

// File: rtl/rto_sync_fifo.sv
// First-word-fall-through FIFO with level count, synchronous clear and asynchronous reset.
module rto_sync_fifo
    import rto_pkg::*;
#(
    parameter int W     = 128,
    parameter int DEPTH = 8192,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          clear,
    input  logic          wr_en,
    input  logic [W-1:0]  din,
    input  logic          rd_en,
    output logic [W-1:0]  dout,
    output logic [LW-1:0] level,
    output logic          empty
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (wr_en && !clear) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two; callers never over/under-run.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            level <= level + LW'(wr_en) - LW'(rd_en);
        end
    end

    assign dout  = mem[rd_ptr];
    assign empty = (level == '0);

endmodule

// File: rtl/rto_core_param.sv
// Real-time-output core: releases buffered timestamped words when the global counter reaches them.
// Optional error counters are built when RTO_ERR_COUNT_EN is defined.
module rto_core_param
    import rto_pkg::*;
#(
    parameter int TS_W        = 64,
    parameter int DATA_W      = 64,
    parameter int DEPTH       = 8192,
    parameter int FULL_THRESH = 8100,
    parameter int LATE_POLICY = LATE_DROP
`ifdef RTO_ERR_COUNT_EN
    ,
    parameter int CNT_W       = 16
`endif
    ,
    localparam int ENTRY_W    = entry_w(TS_W, DATA_W),
    localparam int LW         = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               auto_start,
    input  logic               flush,
    input  logic               err_clear,
    input  logic [TS_W-1:0]    counter,
    rto_if.slave               wr,
    output logic               counter_matched,
    output logic [ENTRY_W-1:0] rto_out,
    output logic               timestamp_error,
    output logic [ENTRY_W-1:0] timestamp_error_data,
    output logic               overflow_error,
    output logic [ENTRY_W-1:0] overflow_error_data,
    output logic               ts_err_sticky,
    output logic               ovf_err_sticky
`ifdef RTO_ERR_COUNT_EN
    ,
    output logic [CNT_W-1:0]   ts_err_count,
    output logic [CNT_W-1:0]   ovf_err_count
`endif
);

    logic [ENTRY_W-1:0] head;
    logic [TS_W-1:0]    head_ts;
    logic [LW-1:0]      fifo_level;
    logic               fifo_empty;
    logic               can_cmp;
    logic               is_match;
    logic               is_late;
    logic               do_pop;
    logic               do_emit;
    logic               do_push;
    logic               do_ovf;

    rto_sync_fifo #(.W(ENTRY_W), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (flush),
        .wr_en   (do_push),
        .din     (wr.fifo_din),
        .rd_en   (do_pop),
        .dout    (head),
        .level   (fifo_level),
        .empty   (fifo_empty)
    );

    assign head_ts  = head[ENTRY_W-1 -: TS_W];
    assign wr.level = fifo_level;
    assign wr.empty = fifo_empty;
    // Registered level: a pop in the same cycle never frees a slot for a write at the threshold.
    assign wr.full  = (fifo_level >= LW'(FULL_THRESH));

    always_comb begin
        can_cmp  = auto_start && !fifo_empty && !flush;
        is_match = can_cmp && (head_ts == counter);
        is_late  = can_cmp && (head_ts < counter);
        do_pop   = is_match || is_late;
        do_emit  = is_match || (is_late && (LATE_POLICY == LATE_EMIT));
        do_push  = wr.write && !wr.full && !flush;
        do_ovf   = wr.write && wr.full && !flush;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            counter_matched      <= 1'b0;
            rto_out              <= '0;
            timestamp_error      <= 1'b0;
            timestamp_error_data <= '0;
            overflow_error       <= 1'b0;
            overflow_error_data  <= '0;
            ts_err_sticky        <= 1'b0;
            ovf_err_sticky       <= 1'b0;
        end else if (flush) begin
            counter_matched      <= 1'b0;
            rto_out              <= '0;
            timestamp_error      <= 1'b0;
            timestamp_error_data <= '0;
            overflow_error       <= 1'b0;
            overflow_error_data  <= '0;
            ts_err_sticky        <= 1'b0;
            ovf_err_sticky       <= 1'b0;
        end else begin
            counter_matched <= do_emit;
            timestamp_error <= is_late;
            overflow_error  <= do_ovf;
            if (do_emit) rto_out              <= head;
            if (is_late) timestamp_error_data <= head;
            if (do_ovf)  overflow_error_data  <= wr.fifo_din;
            // A new error wins over a clear arriving in the same cycle.
            if (is_late)        ts_err_sticky <= 1'b1;
            else if (err_clear) ts_err_sticky <= 1'b0;
            if (do_ovf)         ovf_err_sticky <= 1'b1;
            else if (err_clear) ovf_err_sticky <= 1'b0;
        end
    end

`ifdef RTO_ERR_COUNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ts_err_count  <= '0;
            ovf_err_count <= '0;
        end else if (flush) begin
            ts_err_count  <= '0;
            ovf_err_count <= '0;
        end else begin
            if (err_clear)                                ts_err_count <= CNT_W'(is_late);
            else if (is_late && (ts_err_count != '1))     ts_err_count <= ts_err_count + CNT_W'(1);
            if (err_clear)                                ovf_err_count <= CNT_W'(do_ovf);
            else if (do_ovf && (ovf_err_count != '1))     ovf_err_count <= ovf_err_count + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_rto_core_param.sv
// Bench for rto_core_param: two instances (drop / emit late policy) share one stimulus stream.
module tb_rto_core_param;
    import rto_pkg::*;

    localparam int TS_W   = 16;
    localparam int DATA_W = 16;
    localparam int EW     = TS_W + DATA_W;
    localparam int DEPTH  = 16;
    localparam int FT     = 14;
    localparam int LW     = $clog2(DEPTH + 1);
    localparam int CNT_W  = 2;
    localparam int CMAX   = (1 << CNT_W) - 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic            auto_start = 1'b0;
    logic            flush = 1'b0;
    logic            err_clear = 1'b0;
    logic            write = 1'b0;
    logic [EW-1:0]   din = '0;
    logic [TS_W-1:0] counter = '0;

    rto_if #(.TS_W(TS_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) bus0 ();
    rto_if #(.TS_W(TS_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) bus1 ();
    assign bus0.write    = write;
    assign bus0.fifo_din = din;
    assign bus1.write    = write;
    assign bus1.fifo_din = din;

    logic [1:0]         cm, te, oe, tss, ovs, full_o, empty_o;
    logic [1:0][EW-1:0] ro, ted, oed;
    logic [1:0][LW-1:0] lvl;
    assign full_o[0] = bus0.full;  assign full_o[1] = bus1.full;
    assign empty_o[0] = bus0.empty; assign empty_o[1] = bus1.empty;
    assign lvl[0] = bus0.level;    assign lvl[1] = bus1.level;
`ifdef RTO_ERR_COUNT_EN
    logic [1:0][CNT_W-1:0] tcnt, ocnt;
`endif

    rto_core_param #(.TS_W(TS_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .FULL_THRESH(FT),
                     .LATE_POLICY(LATE_DROP)
`ifdef RTO_ERR_COUNT_EN
                     , .CNT_W(CNT_W)
`endif
    ) u_dut0 (
`ifdef RTO_ERR_COUNT_EN
        .ts_err_count(tcnt[0]), .ovf_err_count(ocnt[0]),
`endif
        .clk(clk), .reset_n(reset_n), .auto_start(auto_start), .flush(flush),
        .err_clear(err_clear), .counter(counter), .wr(bus0),
        .counter_matched(cm[0]), .rto_out(ro[0]), .timestamp_error(te[0]),
        .timestamp_error_data(ted[0]), .overflow_error(oe[0]), .overflow_error_data(oed[0]),
        .ts_err_sticky(tss[0]), .ovf_err_sticky(ovs[0])
    );

    rto_core_param #(.TS_W(TS_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .FULL_THRESH(FT),
                     .LATE_POLICY(LATE_EMIT)
`ifdef RTO_ERR_COUNT_EN
                     , .CNT_W(CNT_W)
`endif
    ) u_dut1 (
`ifdef RTO_ERR_COUNT_EN
        .ts_err_count(tcnt[1]), .ovf_err_count(ocnt[1]),
`endif
        .clk(clk), .reset_n(reset_n), .auto_start(auto_start), .flush(flush),
        .err_clear(err_clear), .counter(counter), .wr(bus1),
        .counter_matched(cm[1]), .rto_out(ro[1]), .timestamp_error(te[1]),
        .timestamp_error_data(ted[1]), .overflow_error(oe[1]), .overflow_error_data(oed[1]),
        .ts_err_sticky(tss[1]), .ovf_err_sticky(ovs[1])
    );

    // ---------------- reference model ----------------
    logic [EW-1:0] m_q[$];
    logic [EW-1:0] m_ro[2];
    logic [EW-1:0] m_ted = '0;
    logic [EW-1:0] m_oed = '0;
    logic          m_tss = 1'b0;
    logic          m_ovs = 1'b0;
    int            m_tcnt = 0;
    int            m_ocnt = 0;
    logic [EW-1:0] exp_rel0_q[$];
    logic [EW-1:0] exp_rel1_q[$];
    logic [EW-1:0] exp_late_q[$];
    logic [EW-1:0] exp_ovf_q[$];

    int n_chk = 0;
    int n_fail = 0;
    bit mon_en = 1'b0;

    function automatic logic [TS_W-1:0] ts_of(input logic [EW-1:0] e);
        return e[EW-1 -: TS_W];
    endfunction

    task automatic m_clear();
        m_q.delete();
        m_ro[0] = '0; m_ro[1] = '0;
        m_ted = '0; m_oed = '0;
        m_tss = 1'b0; m_ovs = 1'b0;
        m_tcnt = 0; m_ocnt = 0;
    endtask

    task automatic m_step();
        logic [EW-1:0] head;
        bit rel, late;
        int cnt_now;
        cnt_now = m_q.size();
        rel = 1'b0; late = 1'b0; head = '0;
        if (auto_start && cnt_now > 0) begin
            head = m_q[0];
            if (ts_of(head) == counter)     rel = 1'b1;
            else if (ts_of(head) < counter) late = 1'b1;
        end
        if (err_clear) begin
            m_tss = 1'b0; m_ovs = 1'b0; m_tcnt = 0; m_ocnt = 0;
        end
        if (rel || late) begin
            void'(m_q.pop_front());
            exp_rel1_q.push_back(head);
            m_ro[1] = head;
            if (rel) begin
                exp_rel0_q.push_back(head);
                m_ro[0] = head;
            end else begin
                exp_late_q.push_back(head);
                m_ted = head;
                m_tss = 1'b1;
                if (m_tcnt < CMAX) m_tcnt++;
            end
        end
        if (write) begin
            if (cnt_now >= FT) begin
                exp_ovf_q.push_back(din);
                m_oed = din;
                m_ovs = 1'b1;
                if (m_ocnt < CMAX) m_ocnt++;
            end else begin
                m_q.push_back(din);
            end
        end
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n)   m_clear();
        else if (flush) m_clear();
        else            m_step();
    end

    // ---------------- scoreboard / monitor ----------------
    task automatic chk(input string name, input int d, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d @%0t: got %0h expected %0h", name, d, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        bit            has_r[2];
        logic [EW-1:0] r[2];
        bit            has_l, has_o;
        logic [EW-1:0] l, o;
        if (mon_en) begin
            has_r[0] = exp_rel0_q.size() > 0; r[0] = '0;
            has_r[1] = exp_rel1_q.size() > 0; r[1] = '0;
            if (has_r[0]) r[0] = exp_rel0_q.pop_front();
            if (has_r[1]) r[1] = exp_rel1_q.pop_front();
            has_l = exp_late_q.size() > 0; l = '0;
            has_o = exp_ovf_q.size() > 0;  o = '0;
            if (has_l) l = exp_late_q.pop_front();
            if (has_o) o = exp_ovf_q.pop_front();
            for (int d = 0; d < 2; d++) begin
                chk("counter_matched", d, 64'(cm[d]), 64'(has_r[d]));
                if (has_r[d] && cm[d]) chk("released_word", d, 64'(ro[d]), 64'(r[d]));
                chk("rto_out_hold", d, 64'(ro[d]), 64'(m_ro[d]));
                chk("timestamp_error", d, 64'(te[d]), 64'(has_l));
                if (has_l && te[d]) chk("late_word", d, 64'(ted[d]), 64'(l));
                chk("timestamp_error_data", d, 64'(ted[d]), 64'(m_ted));
                chk("overflow_error", d, 64'(oe[d]), 64'(has_o));
                if (has_o && oe[d]) chk("rejected_word", d, 64'(oed[d]), 64'(o));
                chk("overflow_error_data", d, 64'(oed[d]), 64'(m_oed));
                chk("ts_err_sticky", d, 64'(tss[d]), 64'(m_tss));
                chk("ovf_err_sticky", d, 64'(ovs[d]), 64'(m_ovs));
                chk("level", d, 64'(lvl[d]), 64'(m_q.size()));
                chk("full", d, 64'(full_o[d]), 64'(m_q.size() >= FT));
                chk("empty", d, 64'(empty_o[d]), 64'(m_q.size() == 0));
`ifdef RTO_ERR_COUNT_EN
                chk("ts_err_count", d, 64'(tcnt[d]), 64'(m_tcnt));
                chk("ovf_err_count", d, 64'(ocnt[d]), 64'(m_ocnt));
`endif
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic push(input logic [TS_W-1:0] ts, input logic [DATA_W-1:0] data);
        write = 1'b1;
        din = {ts, data};
        cyc();
        write = 1'b0;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        m_ro[0] = '0; m_ro[1] = '0;
        mon_en = 1'b1;
        repeat (2) cyc();
        reset_n = 1'b1;
        cyc();

        // On-time release at counter==100
        auto_start = 1'b1;
        counter = 16'd95;
        push(16'd100, 16'h000A);
        for (int c = 96; c <= 105; c++) begin
            counter = TS_W'(c);
            cyc();
        end
        chk("t1_rto_out", 0, 64'(ro[0]), 64'({16'd100, 16'h000A}));

        // Late word: drop vs emit
        counter = 16'd60;
        push(16'd50, 16'h0055);
        cyc(); cyc();
        chk("t2_rto_out_emit", 1, 64'(ro[1]), 64'({16'd50, 16'h0055}));
        err_clear = 1'b1; cyc(); err_clear = 1'b0; cyc();

        // Fill past threshold with compare disabled, then more overflows
        auto_start = 1'b0;
        for (int i = 0; i < 15; i++) push(TS_W'(200 + i), DATA_W'(16'h0100 + i));
        cyc();
        chk("t3_level_at_thresh", 0, 64'(lvl[0]), 64'(FT));
        chk("t3_ovf_data", 0, 64'(oed[0]), 64'({16'd214, 16'h010E}));
        for (int i = 0; i < 4; i++) push(16'd999, DATA_W'(16'h0200 + i));
        cyc();
        err_clear = 1'b1; cyc(); err_clear = 1'b0;
        // Clear and a fresh overflow in the same cycle
        write = 1'b1; din = {16'd998, 16'h0300}; err_clear = 1'b1; cyc();
        write = 1'b0; err_clear = 1'b0; cyc();

        // Flush while late words are streaming out
        counter = 16'd205;
        auto_start = 1'b1;
        repeat (3) cyc();
        flush = 1'b1; write = 1'b1; din = {16'd300, 16'h0400}; cyc();
        flush = 1'b0; write = 1'b0;
        cyc(); cyc();

        // Asynchronous reset during release
        auto_start = 1'b0;
        counter = 16'd299;
        for (int i = 0; i < 4; i++) push(TS_W'(300 + i), DATA_W'(16'h0500 + i));
        auto_start = 1'b1;
        counter = 16'd300; cyc();
        counter = 16'd301; cyc();
        @(negedge clk); #2 reset_n = 1'b0;
        @(negedge clk); #1 reset_n = 1'b1;
        cyc();

        // Steady push+pop at level 5
        auto_start = 1'b0;
        counter = 16'd1000;
        for (int i = 0; i < 5; i++) push(16'd1000, DATA_W'(16'h0600 + i));
        auto_start = 1'b1;
        for (int i = 0; i < 8; i++) push(16'd1000, DATA_W'(16'h0700 + i));
        chk("t5_level_steady", 0, 64'(lvl[0]), 64'(5));
        repeat (8) cyc();

        // Randomized traffic around the counter
        counter = 16'd2000;
        for (int i = 0; i < 400; i++) begin
            counter = counter + TS_W'($urandom_range(0, 2));
            write = ($urandom_range(0, 99) < 60);
            din = {counter + TS_W'($urandom_range(0, 6)) - TS_W'(2), DATA_W'($urandom)};
            auto_start = ($urandom_range(0, 9) != 0);
            err_clear = ($urandom_range(0, 19) == 0);
            flush = ($urandom_range(0, 99) == 0);
            cyc();
        end
        write = 1'b0; err_clear = 1'b0; flush = 1'b0; auto_start = 1'b1;
        counter = counter + TS_W'(20);
        repeat (20) cyc();

        chk("exp_queues_drained", 0,
            64'(exp_rel0_q.size() + exp_rel1_q.size() + exp_late_q.size() + exp_ovf_q.size()), 64'(0));
        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
